// File: rtl/raw_bram_port_arbiter.sv
// Round-robin arbiter sharing one raw BRAM port among NUM_REQ requesters, with
// lockable bursts and owner-tagged read return through the fixed BRAM latency.
module raw_bram_port_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 64,
  parameter int BRAM_LATENCY = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            lock_i,
  input  logic [NUM_REQ-1:0]            we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic                          raw_en,
  output logic [ADDR_WIDTH-1:0]         raw_addr,
  output logic [DATA_WIDTH-1:0]         raw_write_data,
  output logic                          we,
  input  logic [DATA_WIDTH-1:0]         raw_read_data,
  output logic                          dbg_locked
);

  // Handshake: a beat from requester i is accepted in the cycle where
  // req_i[i] & gnt_o[i]; the requester holds its request stable until then.
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {ST_UNLOCKED = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t                  state, state_n;
  logic [IDX_W-1:0]        rr, rr_n;
  logic [IDX_W-1:0]        owner, owner_n;
  logic [IDX_W-1:0]        win;
  logic [IDX_W-1:0]        cand;
  int                      cand_i;
  logic                    found;
  logic                    accept;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    tag_v   [0:BRAM_LATENCY];
  logic [IDX_W-1:0]        tag_own [0:BRAM_LATENCY];

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (int'(i) == NUM_REQ - 1) return '0;
    return i + 1'b1;
  endfunction

  assign dbg_locked = (state == ST_LOCKED);

  // Grant is forced low while reset is held so the port is quiet asynchronously.
  always_comb begin : grant_logic
    gnt_o  = '0;
    win    = '0;
    found  = 1'b0;
    cand   = '0;
    cand_i = 0;
    if (!rst) begin
      if (state == ST_LOCKED) begin
        if (req_i[owner]) begin
          gnt_o[owner] = 1'b1;
          win          = owner;
        end
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          cand_i = int'(rr) + k;
          if (cand_i >= NUM_REQ) cand_i = cand_i - NUM_REQ;
          cand = IDX_W'(cand_i);
          if (!found && req_i[cand]) begin
            found       = 1'b1;
            win         = cand;
            gnt_o[cand] = 1'b1;
          end
        end
      end
    end
  end

  assign accept = |gnt_o;

  always_comb begin : winner_mux
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_o[k]) begin
        sel_we    = we_i[k];
        sel_addr  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin : next_state_logic
    state_n = state;
    rr_n    = rr;
    owner_n = owner;
    if (accept) begin
      if (lock_i[win]) begin
        state_n = ST_LOCKED;
        owner_n = win;
      end else begin
        state_n = ST_UNLOCKED;
        rr_n    = next_idx(win);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_UNLOCKED;
      rr    <= '0;
      owner <= '0;
    end else begin
      state <= state_n;
      rr    <= rr_n;
      owner <= owner_n;
    end
  end

  // Address and write data hold their last value across idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_en         <= 1'b0;
      we             <= 1'b0;
      raw_addr       <= '0;
      raw_write_data <= '0;
    end else if (accept) begin
      raw_en         <= 1'b1;
      we             <= sel_we;
      raw_addr       <= sel_addr;
      raw_write_data <= sel_wdata;
    end else begin
      raw_en <= 1'b0;
      we     <= 1'b0;
    end
  end

  // Stage 0 mirrors the port register; the last stage lines up with read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= BRAM_LATENCY; k++) begin
        tag_v[k]   <= 1'b0;
        tag_own[k] <= '0;
      end
    end else begin
      tag_v[0]   <= accept & ~sel_we;
      tag_own[0] <= win;
      for (int k = 1; k <= BRAM_LATENCY; k++) begin
        tag_v[k]   <= tag_v[k-1];
        tag_own[k] <= tag_own[k-1];
      end
    end
  end

  always_comb begin : read_return
    rvalid_o = '0;
    if (tag_v[BRAM_LATENCY]) rvalid_o[tag_own[BRAM_LATENCY]] = 1'b1;
  end

  assign rdata_o = raw_read_data;

endmodule
